// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared parity types, defaults and the parity helper
package parity_pkg;

   localparam int DEFAULT_DW   = 8;
   localparam int DEFAULT_NREQ = 4;
   localparam int MAX_DW       = 64;

   typedef enum logic {ST_IDLE, ST_HOLD} state_t;

   // Zero-extension of the word leaves its XOR-reduction unchanged.
   function automatic logic parity_calc(input logic [MAX_DW-1:0] word, input logic odd);
      return (^word) ^ odd;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin search from rr_ptr upward with wrap to 0
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  rr_ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  winner
);

   logic found;
   int   idx;

   always_comb begin
      gnt    = '0;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = IDW'(idx);
         end
      end
      if (en && found) gnt[winner] = 1'b1;
   end

endmodule

// File: rtl/parity_rr_sched.sv
// rtl/parity_rr_sched.sv - round-robin sharing of one byte-parity engine
module parity_rr_sched
   import parity_pkg::*;
#(
   parameter int NREQ = DEFAULT_NREQ,
   parameter int DW   = DEFAULT_DW,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] data,
   input  logic               odd_mode,
   output logic [NREQ-1:0]    gnt,
   output logic               out_valid,
   output logic [IDW-1:0]     out_id,
   output logic               out_parity,
   output logic [DW-1:0]      out_data,
   input  logic               out_ready
);

   state_t         state_q, state_d;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] winner;
   logic [DW-1:0]  win_word;
   logic           arb_en;
   logic           load;

   // A draining result frees the engine in the same cycle, so accept overlaps drain.
   assign arb_en   = !rst && ((state_q == ST_IDLE) || out_ready);
   assign win_word = data[winner*DW +: DW];
   assign load     = |gnt;
   assign out_valid = (state_q == ST_HOLD);

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req    (req),
      .rr_ptr (rr_ptr),
      .en     (arb_en),
      .gnt    (gnt),
      .winner (winner)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (load) state_d = ST_HOLD;
         ST_HOLD: if (out_ready && !load) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_ptr     <= '0;
         out_id     <= '0;
         out_data   <= '0;
         out_parity <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            out_data   <= win_word;
            out_id     <= winner;
            out_parity <= parity_calc(MAX_DW'(win_word), odd_mode);
            rr_ptr     <= (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_parity_rr_sched.sv
// tb/tb_parity_rr_sched.sv - scoreboard bench for parity_rr_sched
module tb_parity_rr_sched;

   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int IDW  = 2;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [NREQ-1:0]    req = '0;
   logic [NREQ*DW-1:0] data = '0;
   logic               odd_mode = 1'b0;
   logic               out_ready = 1'b0;
   logic [NREQ-1:0]    gnt;
   logic               out_valid;
   logic [IDW-1:0]     out_id;
   logic               out_parity;
   logic [DW-1:0]      out_data;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int             id;
      logic [DW-1:0]  word;
      logic           par;
   } exp_t;

   exp_t            sb[$];
   int              m_ptr = 0;
   bit              m_held = 1'b0;
   bit              m_acc = 1'b0;
   int              m_win = 0;
   logic [NREQ-1:0] gnt_seen = '0;

   parity_rr_sched #(.NREQ(NREQ), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .data       (data),
      .odd_mode   (odd_mode),
      .gnt        (gnt),
      .out_valid  (out_valid),
      .out_id     (out_id),
      .out_parity (out_parity),
      .out_data   (out_data),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: expected grant from the pointer rule, evaluated mid-cycle.
   always @(negedge clk) begin
      logic [NREQ-1:0] exp_gnt;
      exp_gnt = '0;
      m_acc   = 1'b0;
      if (!rst && (!m_held || out_ready)) begin
         for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (!m_acc && req[i]) begin
               m_acc = 1'b1;
               m_win = i;
            end
         end
      end
      if (m_acc) exp_gnt[m_win] = 1'b1;
      check("gnt", gnt, exp_gnt);
      gnt_seen = gnt;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_held = 1'b0;
         m_ptr  = 0;
         sb.delete();
      end else if (m_acc) begin
         exp_t e;
         e.id   = m_win;
         e.word = data[m_win*DW +: DW];
         e.par  = (^e.word) ^ odd_mode;
         sb.push_back(e);
         m_held = 1'b1;
         m_ptr  = (m_win + 1) % NREQ;
      end else if (m_held && out_ready) begin
         m_held = 1'b0;
      end
   end

   // Monitor: held result must match the oldest expected entry until it drains.
   always @(negedge clk) begin
      check("out_valid", out_valid, sb.size() != 0);
      if (out_valid && sb.size() != 0) begin
         check("out_id", out_id, sb[0].id);
         check("out_data", out_data, sb[0].word);
         check("out_parity", out_parity, sb[0].par);
         if (out_ready) void'(sb.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input int i, input string name);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         tick();
         if (gnt_seen[i]) ok = 1'b1;
      end
      req[i] = 1'b0;
      check(name, ok, 1'b1);
   endtask

   task automatic single(input int i, input logic [7:0] w, input logic odd,
                         input logic exp_par, input string name);
      data[i*DW +: DW] = w;
      odd_mode = odd;
      req[i] = 1'b1;
      wait_gnt(i, {name, "_gnt"});
      check({name, "_par"}, out_parity, exp_par);
      check({name, "_id"}, out_id, i);
      check({name, "_data"}, out_data, w);
   endtask

   initial begin
      int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
      int ngnt;

      tick();
      tick();
      check("rst_valid", out_valid, 1'b0);
      check("rst_id", out_id, 0);
      check("rst_data", out_data, 0);
      rst = 1'b0;
      repeat (5) tick();
      check("idle_valid", out_valid, 1'b0);

      out_ready = 1'b1;
      single(2, 8'hA5, 1'b0, 1'b0, "even_a5");
      single(2, 8'h07, 1'b0, 1'b1, "even_07");
      single(0, 8'hFF, 1'b1, 1'b1, "odd_ff");
      single(0, 8'h01, 1'b1, 1'b0, "odd_01");

      out_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      req = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         logic [NREQ-1:0] e;
         tick();
         e = '0;
         e[exp_seq[k]] = 1'b1;
         check("rr_wrap", gnt_seen, e);
      end
      req = '0;
      repeat (2) tick();

      data[1*DW +: DW] = 8'h03;
      odd_mode = 1'b0;
      out_ready = 1'b0;
      req = 4'b0010;
      ngnt = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (gnt_seen[1]) ngnt++;
         odd_mode = ~odd_mode;
      end
      check("bp_one_gnt", ngnt, 1);
      check("bp_par_frozen", out_parity, 1'b0);
      out_ready = 1'b1;
      tick();
      check("bp_regrant", gnt_seen, 4'b0010);
      req = '0;
      tick();

      data[3*DW +: DW] = 8'h5A;
      out_ready = 1'b0;
      req = 4'b1000;
      wait_gnt(3, "hold3_gnt");
      check("hold3_id", out_id, 3);
      rst = 1'b1;
      tick();
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_id", out_id, 0);
      rst = 1'b0;
      out_ready = 1'b1;
      req = 4'b1001;
      tick();
      check("midrst_first", gnt_seen, 4'b0001);
      req = '0;
      tick();

      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req[i] && gnt_seen[i]) begin
               data[i*DW +: DW] = DW'($urandom);
               req[i] = ($urandom % 2) == 0;
            end else if (!req[i]) begin
               data[i*DW +: DW] = DW'($urandom);
               req[i] = ($urandom % 3) == 0;
            end else if (($urandom % 16) == 0) begin
               req[i] = 1'b0;
            end
         end
         odd_mode = 1'($urandom);
         if (($urandom % 400) == 0) begin
            rst = 1'b1;
            out_ready = 1'b0;
         end else begin
            rst = 1'b0;
            out_ready = ($urandom % 4) != 0;
         end
         tick();
      end

      rst = 1'b0;
      req = '0;
      out_ready = 1'b1;
      repeat (3) tick();
      check("drain_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/parity_rr_sched.md
Name: parity_rr_sched

Overview:
- Round-robin scheduler that shares one byte-parity engine (XOR-reduce of an 8-bit word) between NREQ requesters.
- Each requester raises req with its data word. The scheduler grants one requester per accept and captures that word.
- It computes even or odd parity and returns the result tagged with the winner's ID over a valid/ready output handshake.
- Sits between the per-channel framing logic (UART/packet TX lanes) and the shared parity datapath.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DW, 8, data word width per requester.
- IDW, $clog2(NREQ), width of the requester ID (derived; do not override).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request; requester i holds req[i] and its data slice until gnt[i].
- data  in  NREQ*DW  packed words; requester i drives data[i*DW +: DW].
- odd_mode  in  1  0 = even parity, 1 = odd parity; sampled on the accept cycle.
- gnt  out  NREQ  one-hot, single-cycle accept strobe (combinational from state/req/pointer).
- out_valid  out  1  result held valid.
- out_id  out  IDW  index of the requester whose word produced the result.
- out_parity  out  1  parity bit.
- out_data  out  DW  captured word (echo, for checkers).
- out_ready  in  1  consumer accepts result when out_valid && out_ready.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_id=0, out_parity=0, out_data=0.
  - Round-robin pointer rr_ptr=0, state=IDLE.
  - gnt=0 while rst=1.
- States: IDLE (no result held), HOLD (result held, out_valid=1).
- Accept condition: can_accept = (state==IDLE) || (state==HOLD && out_ready). A result drain and a new accept may occur in the same cycle, giving 1 result/cycle throughput.
- Arbitration, when can_accept && |req:
  - Winner w is the first i with req[i]=1, searching from rr_ptr upward and wrapping NREQ-1 -> 0.
  - gnt[w]=1 for exactly that cycle; otherwise gnt=0.
- On the accept edge:
  - out_data <= data[w], out_id <= w, out_parity <= (^data[w]) ^ odd_mode.
  - out_valid <= 1, state <= HOLD.
  - rr_ptr <= (w==NREQ-1) ? 0 : w+1.
- HOLD with out_ready=0: all outputs stable; gnt=0; req ignored; rr_ptr unchanged.
- HOLD with out_ready=1 and no req: out_valid <= 0, state <= IDLE, rr_ptr unchanged.
- IDLE with no req: nothing changes.
- Latency: gnt cycle N -> out_valid asserted from cycle N+1.
- Fairness: a continuously requesting input is granted within NREQ accepts.
- odd_mode change while in HOLD does not alter the held out_parity.
- Reset mid-operation: a held result is discarded without handshake; the pointer returns to 0.
- A requester dropping req before gnt is legal; it is simply not selected.

Decomposition:
- Package parity_pkg: localparam DEFAULT_DW=8, DEFAULT_NREQ=4; state enum {ST_IDLE, ST_HOLD}; function parity_calc(word, odd) returning ^word ^ odd. This is shared with the existing parity function module.
- One sub-module: rr_arbiter (NREQ param; inputs req, rr_ptr, en; outputs one-hot gnt, winner index). Keeps the masked/wrap search testable on its own.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 -> out_valid=0, gnt=0, out_id=0; release rst, stay idle 5 cycles -> no change.
- Single request, even: req=4'b0100, data[2]=8'hA5, odd_mode=0, out_ready=1 -> gnt=4'b0100 for one cycle; next cycle out_valid=1, out_id=2, out_data=A5, out_parity=0. Repeat with 8'h07 -> out_parity=1.
- Odd mode: data[0]=8'hFF, odd_mode=1 -> out_parity=1; data[0]=8'h01, odd_mode=1 -> out_parity=0.
- Round-robin wrap: all req=1 held, out_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; out_valid high every cycle after the first accept.
- Backpressure: req[1]=1, out_ready=0 for 4 cycles -> one gnt[1] only; outputs frozen; toggle odd_mode -> out_parity unchanged. Raise out_ready -> drain and re-grant in the same cycle.
- Reset mid-HOLD: out_valid=1, out_id=3, rst=1 -> next cycle out_valid=0, out_id=0. With req=4'b1001 after release -> requester 0 granted first (pointer back to 0).
